unique_0: RTL and testbench
===========================

Name: unique_0

Overview:
- 16-QAM Gray-coded symbol mapper.
- Takes one 4-bit symbol per handshake and emits signed I/Q amplitudes from {-3,-1,+1,+3}, registered with one cycle of latency.
- Sits between the bit-grouping front end and the I/Q carrier multiplier/DAC path.
- Symbol acceptance is gated by the carrier zero-crossing strobe cor_zero, so symbol changes align to carrier phase.

Parameters:
- OUT_W, 3: width of mod_i/mod_q in bits, two's complement, legal range 3..16; values sign-extended to OUT_W.
- CNT_W, 16: width of the sym_cnt output; only used when UNIQUE0_SYM_CNT_EN is defined.

Ports:
- axi_clk  in  1  single clock; all logic rising-edge.
- axi_rst  in  1  synchronous, active-high reset.
- cor_zero  in  1  carrier zero-crossing strobe; a symbol is accepted only when high.
- din_valid  in  1  input symbol valid.
- din_ready  out  1  input ready.
- din  in  4  symbol; [1:0] selects I level, [3:2] selects Q level.
- mod_ready  in  1  downstream accepts output.
- mod_valid  out  1  output symbol valid.
- mod_i  out  OUT_W  signed I-channel amplitude.
- mod_q  out  OUT_W  signed Q-channel amplitude.
- sym_cnt  out  CNT_W  accepted-symbol count (optional; see below).

Behaviour:
- Reset (axi_rst high at a rising edge): mod_valid=0, mod_i=0, mod_q=0, sym_cnt=0. Reset dominates all other inputs. Reset mid-transfer discards the held symbol.
- din_ready is combinational: din_ready = cor_zero AND (mod_valid==0 OR mod_ready==1).
- Accept event: din_valid AND din_ready at a rising edge. On the next edge, mod_valid=1 and mod_i/mod_q are loaded with the mapped values. Latency is exactly 1 cycle.
- Gray mapping, applied identically per channel (I from din[1:0], Q from din[3:2]):
  - 00 -> -3
  - 01 -> +3
  - 11 -> +1
  - 10 -> -1
- All 16 codes are legal; there is no error path.
- Output hold: while mod_valid=1 and mod_ready=0, mod_valid/mod_i/mod_q hold stable and din_ready=0.
- Drain: if mod_valid=1, mod_ready=1 and there is no accept event in the same cycle, then next cycle mod_valid=0 and mod_i=mod_q=0. Outputs are zero whenever invalid.
- Simultaneous drain and accept: the new symbol replaces the old one in the same edge, with no bubble. Full throughput is 1 symbol/cycle when cor_zero=1 continuously.
- Gating: cor_zero=0 blocks acceptance but does not affect draining.
- No internal state beyond the output register and the optional counter.

Optional Feature:
- Macro UNIQUE0_SYM_CNT_EN.
- Defined: sym_cnt increments by 1 on each accept event, wraps modulo 2^CNT_W (all ones -> 0), and resets to 0.
- Undefined: sym_cnt is tied to constant 0 and no counter logic is synthesized. The port is still present.

Test Plan:
- Reset: hold axi_rst=1 for 3 cycles with din_valid=1, cor_zero=1 -> mod_valid=0, mod_i=0, mod_q=0, sym_cnt=0 throughout.
- Full mapping sweep: mod_ready=1, cor_zero=1, din=0..15 on consecutive cycles -> each value appears one cycle later. Examples: din=4'b0000 -> I=-3,Q=-3; 4'b0001 -> I=+3,Q=-3; 4'b0111 -> I=+1,Q=+3; 4'b1110 -> I=-1,Q=+1; 4'b1010 -> I=-1,Q=-1. mod_valid stays 1 for all 16 cycles.
- cor_zero gating: din_valid=1, din=4'b0101, cor_zero=0 for 5 cycles, then 1 -> din_ready=0 and mod_valid=0 during the low period; I=+3,Q=+3 one cycle after cor_zero rises.
- Backpressure: load din=4'b1101, then mod_ready=0 for 4 cycles with new din offered -> outputs hold I=+3,Q=+1 and din_ready=0; on mod_ready=1 the next symbol replaces it with no bubble.
- Drain to idle: a single symbol then din_valid=0 with mod_ready=1 -> one valid cycle, then mod_valid=0, mod_i=mod_q=0.
- Counter (macro defined, CNT_W=4): 17 accepts -> sym_cnt reads 1 after wrap. Assert axi_rst mid-stream -> sym_cnt=0 on the next cycle.

Source files
------------

// File: rtl/unique_0.sv
// ---------------------------------------------------------------------------
// unique_0 : 16-QAM Gray-coded symbol mapper
//
// Accepts one 4-bit symbol per input handshake. It maps din[1:0] to the I
// amplitude and din[3:2] to the Q amplitude. Each amplitude is one of
// {-3,-1,+1,+3}, in two's complement and sign-extended to OUT_W bits. The
// mapped pair is registered, so it appears exactly one cycle after the accept.
//
// A symbol is accepted only while the carrier zero-crossing strobe cor_zero
// is high. This keeps symbol changes aligned to carrier phase. Draining the
// output register does not depend on cor_zero.
//
// Optional feature macro: UNIQUE0_SYM_CNT_EN
//   defined   : sym_cnt counts accepted symbols, wrapping modulo 2^CNT_W
//   undefined : sym_cnt is tied to zero and no counter is built
//
// Parameters
//   OUT_W  width of mod_i / mod_q (3..16)
//   CNT_W  width of sym_cnt
//
// Ports
//   axi_clk    in   clock, all logic on the rising edge
//   axi_rst    in   synchronous active-high reset
//   cor_zero   in   carrier zero-crossing strobe, gates acceptance
//   din_valid  in   input symbol valid
//   din_ready  out  input ready (combinational)
//   din        in   symbol: [1:0] selects the I level, [3:2] selects the Q level
//   mod_ready  in   downstream accepts the output
//   mod_valid  out  output symbol valid
//   mod_i      out  signed I amplitude
//   mod_q      out  signed Q amplitude
//   sym_cnt    out  accepted-symbol count
//
// Handshake semantics (both ports): a transfer happens at a rising edge where
// valid and ready are both high. Once a producer raises valid, it keeps valid
// and data stable until that transfer. On the output side, mod_valid/mod_i/mod_q
// hold while mod_ready is low. Ready may depend combinationally on the other
// side's ready, but never on its own port's valid.
// ---------------------------------------------------------------------------
module unique_0 #(
    parameter int OUT_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             axi_clk,
    input  logic             axi_rst,
    input  logic             cor_zero,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [3:0]       din,
    input  logic             mod_ready,
    output logic             mod_valid,
    output logic [OUT_W-1:0] mod_i,
    output logic [OUT_W-1:0] mod_q,
    output logic [CNT_W-1:0] sym_cnt
);

    // Amplitude levels, already sign-extended to the output width.
    localparam logic [OUT_W-1:0] LVL_P3 = OUT_W'(3);
    localparam logic [OUT_W-1:0] LVL_P1 = OUT_W'(1);
    localparam logic [OUT_W-1:0] LVL_N1 = OUT_W'(-1);
    localparam logic [OUT_W-1:0] LVL_N3 = OUT_W'(-3);

    // Gray mapping. Adjacent levels differ in exactly one bit:
    // 00 -> -3, 10 -> -1, 11 -> +1, 01 -> +3.
    function automatic logic [OUT_W-1:0] gray_level(input logic [1:0] code);
        logic [OUT_W-1:0] lvl;
        lvl = LVL_N3;
        case (code)
            2'b00:   lvl = LVL_N3;
            2'b01:   lvl = LVL_P3;
            2'b11:   lvl = LVL_P1;
            2'b10:   lvl = LVL_N1;
            default: lvl = LVL_N3;
        endcase
        return lvl;
    endfunction

    logic             accept;
    logic             drain;
    logic [OUT_W-1:0] next_i;
    logic [OUT_W-1:0] next_q;

    // The register can take a new symbol when it is empty or being emptied
    // this cycle. The carrier strobe decides whether it is allowed to.
    assign din_ready = cor_zero & (~mod_valid | mod_ready);
    assign accept    = din_valid & din_ready;
    assign drain     = mod_valid & mod_ready;

    assign next_i = gray_level(din[1:0]);
    assign next_q = gray_level(din[3:2]);

    // Output register. An accept wins over a drain in the same cycle, so a
    // continuous stream runs at one symbol per cycle with no bubble. Outputs
    // are forced to zero whenever the register is empty.
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            mod_valid <= 1'b0;
            mod_i     <= '0;
            mod_q     <= '0;
        end else if (accept) begin
            mod_valid <= 1'b1;
            mod_i     <= next_i;
            mod_q     <= next_q;
        end else if (drain) begin
            mod_valid <= 1'b0;
            mod_i     <= '0;
            mod_q     <= '0;
        end
    end

`ifdef UNIQUE0_SYM_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Accepted-symbol counter, wrapping naturally at all ones.
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sym_cnt = cnt;
`else
    assign sym_cnt = '0;
`endif

endmodule

// File: tb/tb_unique_0.sv
// ---------------------------------------------------------------------------
// tb_unique_0 : directed self-checking bench for unique_0 (OUT_W=3, CNT_W=4)
//
// Covers reset, the full 16-code mapping sweep, cor_zero gating,
// backpressure hold with no-bubble replacement, drain to idle, draining with
// cor_zero low, reset during a transfer, and the symbol counter (its wrap
// when UNIQUE0_SYM_CNT_EN is defined, constant zero otherwise).
// ---------------------------------------------------------------------------
module tb_unique_0;

    localparam int OUT_W = 3;
    localparam int CNT_W = 4;

    logic             axi_clk;
    logic             axi_rst;
    logic             cor_zero;
    logic             din_valid;
    logic             din_ready;
    logic [3:0]       din;
    logic             mod_ready;
    logic             mod_valid;
    logic [OUT_W-1:0] mod_i;
    logic [OUT_W-1:0] mod_q;
    logic [CNT_W-1:0] sym_cnt;

    int n_checks;
    int n_bad;

    unique_0 #(
        .OUT_W(OUT_W),
        .CNT_W(CNT_W)
    ) dut (
        .axi_clk  (axi_clk),
        .axi_rst  (axi_rst),
        .cor_zero (cor_zero),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .din      (din),
        .mod_ready(mod_ready),
        .mod_valid(mod_valid),
        .mod_i    (mod_i),
        .mod_q    (mod_q),
        .sym_cnt  (sym_cnt)
    );

    // ---------------- clock ----------------
    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Hand table of 3-bit two's complement levels.
    function automatic logic [OUT_W-1:0] lvl(input logic [1:0] c);
        case (c)
            2'b00:   return 3'b101; // -3
            2'b01:   return 3'b011; // +3
            2'b11:   return 3'b001; // +1
            default: return 3'b111; // -1
        endcase
    endfunction

    // ---------------- driver helpers ----------------
    // Inputs change 1 time unit after a rising edge. Outputs are sampled there too.
    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v,
                              input logic [OUT_W-1:0] ei, input logic [OUT_W-1:0] eq);
        check_eq({tag, "_valid"}, 32'(mod_valid), 32'(v));
        check_eq({tag, "_i"},     32'(mod_i),     32'(ei));
        check_eq({tag, "_q"},     32'(mod_q),     32'(eq));
    endtask

`ifdef UNIQUE0_SYM_CNT_EN
    localparam logic [CNT_W-1:0] CNT_AFTER_SWEEP = 4'd0;  // 16 accepts wrap to 0
    localparam logic [CNT_W-1:0] CNT_AFTER_17    = 4'd1;
`else
    localparam logic [CNT_W-1:0] CNT_AFTER_SWEEP = 4'd0;
    localparam logic [CNT_W-1:0] CNT_AFTER_17    = 4'd0;
`endif

    // ---------------- stimulus ----------------
    initial begin
        n_checks  = 0;
        n_bad     = 0;
        axi_rst   = 1'b1;
        cor_zero  = 1'b1;
        din_valid = 1'b1;
        din       = 4'b0101;
        mod_ready = 1'b1;

        // Reset held for 3 cycles while a symbol is offered.
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_out("reset", 1'b0, 3'b000, 3'b000);
            check_eq("reset_cnt", 32'(sym_cnt), 32'd0);
        end

        // Full mapping sweep, one accept per cycle.
        axi_rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] code;
            code = 4'(k);
            din  = code;
            #1;
            check_eq("sweep_ready", 32'(din_ready), 32'd1);
            tick();
            expect_out($sformatf("sweep%0d", k), 1'b1, lvl(code[1:0]), lvl(code[3:2]));
        end
        check_eq("cnt_sweep", 32'(sym_cnt), 32'(CNT_AFTER_SWEEP));

        // Drain after the sweep.
        din_valid = 1'b0;
        tick();
        expect_out("drain_sweep", 1'b0, 3'b000, 3'b000);

        // cor_zero gating.
        din_valid = 1'b1;
        din       = 4'b0101;
        cor_zero  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("gate_ready", 32'(din_ready), 32'd0);
            tick();
            check_eq("gate_valid", 32'(mod_valid), 32'd0);
        end
        cor_zero = 1'b1;
        #1;
        check_eq("gate_open_ready", 32'(din_ready), 32'd1);
        tick();
        expect_out("gate_load", 1'b1, 3'b011, 3'b011);
        check_eq("cnt_wrap", 32'(sym_cnt), 32'(CNT_AFTER_17));

        // Backpressure: load 1101, then hold for 4 cycles while 0000 is offered.
        din = 4'b1101;
        tick();
        expect_out("bp_load", 1'b1, 3'b011, 3'b001);
        mod_ready = 1'b0;
        din       = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("bp_ready", 32'(din_ready), 32'd0);
            tick();
            expect_out("bp_hold", 1'b1, 3'b011, 3'b001);
        end
        mod_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", 32'(din_ready), 32'd1);
        tick();
        expect_out("bp_replace", 1'b1, 3'b101, 3'b101);

        // Drain to idle after a single symbol.
        din = 4'b1010;
        tick();
        expect_out("single", 1'b1, 3'b111, 3'b111);
        din_valid = 1'b0;
        tick();
        expect_out("drain_idle", 1'b0, 3'b000, 3'b000);
        tick();
        expect_out("idle_stay", 1'b0, 3'b000, 3'b000);

        // Draining proceeds with cor_zero low.
        din_valid = 1'b1;
        din       = 4'b1110;
        tick();
        expect_out("cz_load", 1'b1, 3'b111, 3'b001);
        din_valid = 1'b0;
        cor_zero  = 1'b0;
        tick();
        expect_out("cz_drain", 1'b0, 3'b000, 3'b000);

        // Reset in the middle of a stalled transfer discards the symbol.
        cor_zero  = 1'b1;
        din_valid = 1'b1;
        din       = 4'b0111;
        tick();
        expect_out("pre_rst", 1'b1, 3'b001, 3'b011);
        mod_ready = 1'b0;
        axi_rst   = 1'b1;
        tick();
        expect_out("mid_rst", 1'b0, 3'b000, 3'b000);
        check_eq("mid_rst_cnt", 32'(sym_cnt), 32'd0);
        axi_rst   = 1'b0;
        mod_ready = 1'b1;
        din_valid = 1'b0;
        tick();
        expect_out("post_rst", 1'b0, 3'b000, 3'b000);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
